// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the SPI bus scheduler.
// Holds the scheduler state enum, the snapshot error bit indices and the default data widths.
package alarm_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ALS_WAIT,
        ALS_XFER,
        GAP,
        ACL_WAIT,
        ACL_XFER,
        DONE
    } spi_sched_state_t;
    localparam int ERR_ALS = 0;
    localparam int ERR_ACL = 1;
    localparam int ALS_W   = 8;
    localparam int ACL_W   = 32;
endpackage

// File: rtl/spi_watchdog.sv
// spi_watchdog: per-device timeout counter shared by both scheduler phases.
// Ports: clk, rst_n (async, active-low), clear (restart at zero), run (count this cycle),
//        expired (counter has reached TIMEOUT; it saturates there).
module spi_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    assign expired = count == LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (run && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/spi_bus_sched.sv
// spi_bus_sched: round-robin SPI bus scheduler, ALS then ACL2, publishing one atomic snapshot per round.
// Ports: clk, rst_n (async, active-low); tick (round request);
//        als_ready/als_fetch/als_arr/als_illum and acl_ready/acl_fetch/acl_arr/acl_acc (driver handshakes);
//        als_clk_ena/acl_clk_ena (SCLK gates, mutually exclusive);
//        illum/acc/snap_err/snap_valid (published snapshot); busy (round in progress).
module spi_bus_sched #(
    parameter int TIMEOUT = 100000,
    parameter int ALS_W   = alarm_pkg::ALS_W,
    parameter int ACL_W   = alarm_pkg::ACL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             als_ready,
    output logic             als_fetch,
    input  logic             als_arr,
    input  logic [ALS_W-1:0] als_illum,
    input  logic             acl_ready,
    output logic             acl_fetch,
    input  logic             acl_arr,
    input  logic [ACL_W-1:0] acl_acc,
    output logic             als_clk_ena,
    output logic             acl_clk_ena,
    output logic [ALS_W-1:0] illum,
    output logic [ACL_W-1:0] acc,
    output logic             snap_valid,
    output logic [1:0]       snap_err,
    output logic             busy
);
    import alarm_pkg::*;

    spi_sched_state_t state, state_n;
    logic             pending, pending_n;
    logic [1:0]       err, err_n;
    logic             als_fetch_n, acl_fetch_n, als_ena_n, acl_ena_n, busy_n;
    logic             als_take, acl_take, publish;
    logic             wd_clear, wd_run, expired;
    logic [ALS_W-1:0] als_sh;
    logic [ACL_W-1:0] acl_sh;

    spi_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(expired)
    );

    always_comb begin
        state_n     = state;
        pending_n   = pending | (tick & (state != IDLE));
        err_n       = err;
        als_fetch_n = 1'b0;
        acl_fetch_n = 1'b0;
        als_ena_n   = 1'b0;
        acl_ena_n   = 1'b0;
        als_take    = 1'b0;
        acl_take    = 1'b0;
        publish     = 1'b0;
        case (state)
            IDLE: if (tick || pending) begin
                state_n   = ALS_WAIT;
                pending_n = 1'b0;
            end
            // a device that never becomes ready is abandoned like one that never answers
            ALS_WAIT: if (expired) begin
                state_n        = GAP;
                err_n[ERR_ALS] = 1'b1;
            end else if (als_ready) begin
                state_n     = ALS_XFER;
                als_fetch_n = 1'b1;
                als_ena_n   = 1'b1;
            end
            // arrival is checked first so data landing on the timeout edge is kept
            ALS_XFER: if (als_arr) begin
                als_take = 1'b1;
                state_n  = GAP;
            end else if (expired) begin
                err_n[ERR_ALS] = 1'b1;
                state_n        = GAP;
            end else
                als_ena_n = 1'b1;
            GAP: state_n = ACL_WAIT;
            ACL_WAIT: if (expired) begin
                state_n        = DONE;
                err_n[ERR_ACL] = 1'b1;
                publish        = 1'b1;
            end else if (acl_ready) begin
                state_n     = ACL_XFER;
                acl_fetch_n = 1'b1;
                acl_ena_n   = 1'b1;
            end
            ACL_XFER: if (acl_arr) begin
                acl_take = 1'b1;
                state_n  = DONE;
                publish  = 1'b1;
            end else if (expired) begin
                err_n[ERR_ACL] = 1'b1;
                state_n        = DONE;
                publish        = 1'b1;
            end else
                acl_ena_n = 1'b1;
            // a queued request starts the next round straight away; a tick seen here queues a new one
            DONE: begin
                state_n   = pending ? ALS_WAIT : IDLE;
                pending_n = tick;
                err_n     = '0;
            end
            default: state_n = IDLE;
        endcase
        wd_clear = (state_n inside {ALS_WAIT, ACL_WAIT}) && state_n != state;
        wd_run   = state inside {ALS_WAIT, ALS_XFER, ACL_WAIT, ACL_XFER};
        busy_n   = state_n inside {ALS_WAIT, ALS_XFER, GAP, ACL_WAIT, ACL_XFER};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            err         <= '0;
            als_fetch   <= 1'b0;
            acl_fetch   <= 1'b0;
            als_clk_ena <= 1'b0;
            acl_clk_ena <= 1'b0;
            busy        <= 1'b0;
            snap_valid  <= 1'b0;
            snap_err    <= '0;
            illum       <= '0;
            acc         <= '0;
            als_sh      <= '0;
            acl_sh      <= '0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            err         <= err_n;
            als_fetch   <= als_fetch_n;
            acl_fetch   <= acl_fetch_n;
            als_clk_ena <= als_ena_n;
            acl_clk_ena <= acl_ena_n;
            busy        <= busy_n;
            snap_valid  <= publish;
            if (als_take)
                als_sh <= als_illum;
            if (acl_take)
                acl_sh <= acl_acc;
            // the ACL2 word may arrive on the publishing edge itself, so bypass its shadow
            if (publish) begin
                illum    <= als_sh;
                acc      <= acl_take ? acl_acc : acl_sh;
                snap_err <= err_n;
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_sched.sv
// tb_spi_bus_sched: randomized round-level reference model with per-cycle output comparison.
module tb_spi_bus_sched;
    localparam int TO = 64;
    localparam int N  = 9000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick, als_ready, als_arr, acl_ready, acl_arr;
    logic [7:0]  als_illum;
    logic [31:0] acl_acc;
    logic        als_fetch, acl_fetch, als_clk_ena, acl_clk_ena, snap_valid, busy;
    logic [7:0]  illum;
    logic [31:0] acc;
    logic [1:0]  snap_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit run = 1'b0;

    // cycle k is the period just before edge k: inputs of cycle k are sampled at edge k
    bit          i_tick[N], i_ar[N], i_aa[N], i_cr[N], i_ca[N];
    logic [7:0]  i_ad[N];
    logic [31:0] i_cd[N];
    bit          e_af[N], e_ae[N], e_cf[N], e_ce[N], e_busy[N], e_sv[N];
    logic [7:0]  e_il[N];
    logic [31:0] e_ac[N];
    logic [1:0]  e_er[N];
    logic [7:0]  sh_il = 8'h00;
    logic [31:0] sh_ac = 32'h0;

    spi_bus_sched #(.TIMEOUT(TO), .ALS_W(8), .ACL_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .als_ready  (als_ready),
        .als_fetch  (als_fetch),
        .als_arr    (als_arr),
        .als_illum  (als_illum),
        .acl_ready  (acl_ready),
        .acl_fetch  (acl_fetch),
        .acl_arr    (acl_arr),
        .acl_acc    (acl_acc),
        .als_clk_ena(als_clk_ena),
        .acl_clk_ena(acl_clk_ena),
        .illum      (illum),
        .acc        (acc),
        .snap_valid (snap_valid),
        .snap_err   (snap_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s cycle=%0d t=%0t got=%h want=%h", nm, cyc, $time, got, want);
        end
    endtask

    // One device phase starting with its wait state in cycle w: ready first seen ra cycles
    // later, data arriving an cycles after w. The device is done in cycle fin.
    task automatic dev(input bit acl, input int w, input int ra, input int an, input logic [31:0] d,
                       output int fin, output bit ok);
        bit rdy_ok, rdy, arr, fe, en;
        rdy_ok = ra < TO;
        ok = rdy_ok && an > ra && an <= TO;
        fin = ok ? w + an : w + TO;
        for (int c = w; c <= fin; c++) begin
            rdy = rdy_ok && c == w + ra;
            arr = ok && c == w + an;
            fe  = rdy_ok && c == w + ra + 1;
            en  = rdy_ok && c > w + ra;
            if (acl) begin
                if (c <= w + ra) i_cr[c] = rdy;
                i_ca[c] = arr;
                if (arr) i_cd[c] = d;
                e_cf[c] = fe;
                e_ce[c] = en;
            end else begin
                if (c <= w + ra) i_ar[c] = rdy;
                i_aa[c] = arr;
                if (arr) i_ad[c] = d[7:0];
                e_af[c] = fe;
                e_ae[c] = en;
            end
        end
    endtask

    task automatic run_round(input int w, input int ra, input int an, input int rb, input int bn,
                             input logic [7:0] da, input logic [31:0] dc, output int m);
        int  fa;
        bit  oka, okc;
        dev(1'b0, w, ra, an, {24'h0, da}, fa, oka);
        i_ca[w] = 1'b1;
        i_aa[fa + 2] = 1'b1;
        dev(1'b1, fa + 2, rb, bn, dc, m, okc);
        for (int c = w; c <= m; c++) e_busy[c] = 1'b1;
        if (oka) sh_il = da;
        if (okc) sh_ac = dc;
        e_sv[m + 1] = 1'b1;
        e_il[m + 1] = sh_il;
        e_ac[m + 1] = sh_ac;
        e_er[m + 1] = {!okc, !oka};
    endtask

    task automatic pick(output int ra, output int an);
        int k;
        k = int'($urandom_range(0, 9));
        ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 20)) : int'($urandom_range(0, 30));
        an = (k == 0) ? TO : (k == 1) ? TO + 1 + int'($urandom_range(0, 9)) : ra + 1 + int'($urandom_range(0, 30));
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("als_fetch", als_fetch, e_af[cyc]);
            chk("als_clk_ena", als_clk_ena, e_ae[cyc]);
            chk("acl_fetch", acl_fetch, e_cf[cyc]);
            chk("acl_clk_ena", acl_clk_ena, e_ce[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("snap_valid", snap_valid, e_sv[cyc]);
            chk("illum", illum, e_il[cyc]);
            chk("acc", acc, e_ac[cyc]);
            chk("snap_err", snap_err, e_er[cyc]);
            chk("ena_overlap", als_clk_ena & acl_clk_ena, 0);
            if (cyc == 1) chk("pin_reset_busy", busy, 0);
            if (cyc == 7) chk("pin_als_fetch", als_fetch, 1);
            if (cyc == 8) chk("pin_als_fetch_once", als_fetch, 0);
            if (cyc == 26) chk("pin_als_ena_last", als_clk_ena, 1);
            if (cyc == 27) chk("pin_gap", {busy, als_clk_ena, acl_clk_ena}, 3'b100);
            if (cyc == 29) chk("pin_acl_fetch", acl_fetch, 1);
            if (cyc == 69) chk("pin_snap1", {snap_valid, busy, snap_err, illum, acc}, {1'b1, 1'b0, 2'b00, 8'h5A, 32'h0012_3456});
            if (cyc == 145) chk("pin_timeout_ena_hi", als_clk_ena, 1);
            if (cyc == 146) chk("pin_timeout_ena_lo", als_clk_ena, 0);
            if (cyc == 212) chk("pin_snap2", {snap_valid, snap_err, illum, acc}, {1'b1, 2'b01, 8'h5A, 32'hCAFE_0001});
        end
    end

    initial begin
        int m, w, mode, t, ra, an, rb, bn;
        bit first;
        logic [7:0]  ci;
        logic [31:0] ca;
        logic [1:0]  ce;
        for (int c = 0; c < N; c++) begin
            i_tick[c] = 1'b0;
            i_ar[c] = 1'($urandom_range(0, 1));
            i_cr[c] = 1'($urandom_range(0, 1));
            i_aa[c] = $urandom_range(0, 15) == 0;
            i_ca[c] = $urandom_range(0, 15) == 0;
            i_ad[c] = 8'($urandom);
            i_cd[c] = $urandom;
        end
        i_tick[5] = 1'b1;
        run_round(6, 0, 20, 0, 40, 8'h5A, 32'h0012_3456, m);
        i_tick[80] = 1'b1;
        run_round(81, 0, TO + 30, 0, TO, 8'h00, 32'hCAFE_0001, m);
        w = m + 6;
        i_tick[w - 1] = 1'b1;
        first = 1'b1;
        while (1) begin
            pick(ra, an);
            pick(rb, bn);
            run_round(w, ra, an, rb, bn, 8'($urandom), $urandom, m);
            if (m > N - 400) break;
            mode = first ? 0 : int'($urandom_range(0, 2));
            first = 1'b0;
            if (mode == 0) begin
                repeat ($urandom_range(1, 3)) i_tick[$urandom_range(w, m)] = 1'b1;
                w = m + 2;
            end else if (mode == 1) begin
                i_tick[m + 1] = 1'b1;
                w = m + 3;
            end else begin
                t = m + 2 + int'($urandom_range(0, 10));
                i_tick[t] = 1'b1;
                w = t + 1;
            end
        end
        ci = 8'h00;
        ca = 32'h0;
        ce = 2'b00;
        for (int c = 0; c < N; c++) begin
            if (e_sv[c]) begin
                ci = e_il[c];
                ca = e_ac[c];
                ce = e_er[c];
            end
            e_il[c] = ci;
            e_ac[c] = ca;
            e_er[c] = ce;
        end

        tick = 1'b0; als_ready = 1'b0; als_arr = 1'b0; acl_ready = 1'b0; acl_arr = 1'b0;
        als_illum = 8'h00; acl_acc = 32'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b1;
        for (int k = 0; k < N; k++) begin
            cyc = k;
            tick = i_tick[k];
            als_ready = i_ar[k];
            als_arr = i_aa[k];
            als_illum = i_ad[k];
            acl_ready = i_cr[k];
            acl_arr = i_ca[k];
            acl_acc = i_cd[k];
            @(posedge clk);
            #1;
        end
        run = 1'b0;

        tick = 1'b0; als_ready = 1'b0; als_arr = 1'b0; acl_ready = 1'b0; acl_arr = 1'b0;
        @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        als_ready = 1'b1;
        acl_ready = 1'b1;
        for (int i = 0; i < 10 && !als_clk_ena; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_reach_als_xfer", als_clk_ena, 1);
        als_arr = 1'b1;
        als_illum = 8'h33;
        @(posedge clk);
        #1;
        als_arr = 1'b0;
        for (int i = 0; i < 10 && !acl_clk_ena; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_reach_acl_xfer", {acl_clk_ena, busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {als_fetch, acl_fetch, als_clk_ena, acl_clk_ena, snap_valid, busy, snap_err, illum, acc}, 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            als_ready = 1'($urandom_range(0, 1));
            acl_ready = 1'($urandom_range(0, 1));
            als_arr = 1'($urandom_range(0, 1));
            acl_arr = 1'($urandom_range(0, 1));
            als_illum = 8'($urandom);
            acl_acc = $urandom;
            @(negedge clk);
            chk("post_rst_quiet", {als_fetch, acl_fetch, als_clk_ena, acl_clk_ena, snap_valid, busy, snap_err, illum, acc}, 0);
            @(posedge clk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
